// File: rtl/uart_pkg.sv
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared UART types and constants (FSM encoding, oversampling).
// Revision: 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int OVERSAMPLE  = 16;
    localparam int SB_TICK_1   = 16;
    localparam int SB_TICK_1P5 = 24;
    localparam int SB_TICK_2   = 32;

    localparam logic [4:0] c_BIT_MID  = 5'(OVERSAMPLE / 2 - 1);
    localparam logic [4:0] c_BIT_LAST = 5'(OVERSAMPLE - 1);

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync_2ff.sv
// ============================================================================
// Module  : sync_2ff
// Brief   : Two-flop synchroniser for an asynchronous level, with a
//           configurable reset value.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module  : uart_rx
// Brief   : 16x-oversampled UART receiver with optional parity and
//           framing/parity error flags.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            parity_err
);

    localparam logic [2:0] c_N_LAST    = 3'(DBIT - 1);
    localparam logic [4:0] c_STOP_LAST = 5'(SB_TICK - 1);
    localparam logic       c_PAR_ODD   = (PARITY_ODD != 0);
    localparam logic       c_PAR_EN    = (PARITY_EN != 0);

    logic w_rx_s;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (rx),
        .o_q (w_rx_s)
    );

    state_t          r_state, w_state;
    logic [4:0]      r_s,     w_s;
    logic [2:0]      r_n,     w_n;
    logic [DBIT-1:0] r_shift, w_shift;
    logic            r_p,     w_p;
    logic [DBIT-1:0] r_dout,  w_dout;
    logic            r_done,  w_done;
    logic            r_ferr,  w_ferr;
    logic            r_perr,  w_perr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_shift <= '0;
            r_p     <= 1'b0;
            r_dout  <= '0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
            r_perr  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_s     <= w_s;
            r_n     <= w_n;
            r_shift <= w_shift;
            r_p     <= w_p;
            r_dout  <= w_dout;
            r_done  <= w_done;
            r_ferr  <= w_ferr;
            r_perr  <= w_perr;
        end
    end

    always_comb begin
        w_state = r_state;
        w_s     = r_s;
        w_n     = r_n;
        w_shift = r_shift;
        w_p     = r_p;
        w_dout  = r_dout;
        w_done  = 1'b0;
        w_ferr  = r_ferr;
        w_perr  = r_perr;

        case (r_state)
            IDLE: begin
                if (!w_rx_s) begin
                    w_state = START;
                    w_s     = '0;
                end
            end
            START: begin
                // A start bit that is high again at its centre is a glitch.
                if (s_tick) begin
                    if (r_s == c_BIT_MID) begin
                        if (!w_rx_s) begin
                            w_state = DATA;
                            w_s     = '0;
                            w_n     = '0;
                        end else begin
                            w_state = IDLE;
                        end
                    end else begin
                        w_s = r_s + 5'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (r_s == c_BIT_LAST) begin
                        w_shift = {w_rx_s, r_shift[DBIT-1:1]};
                        w_s     = '0;
                        if (r_n == c_N_LAST) begin
                            w_state = c_PAR_EN ? PARITY : STOP;
                        end else begin
                            w_n = r_n + 3'd1;
                        end
                    end else begin
                        w_s = r_s + 5'd1;
                    end
                end
            end
            PARITY: begin
                if (s_tick) begin
                    if (r_s == c_BIT_LAST) begin
                        w_p     = w_rx_s;
                        w_s     = '0;
                        w_state = STOP;
                    end else begin
                        w_s = r_s + 5'd1;
                    end
                end
            end
            STOP: begin
                // Frames with a bad stop bit are still delivered, flagged.
                if (s_tick) begin
                    if (r_s == c_STOP_LAST) begin
                        w_state = IDLE;
                        w_dout  = r_shift;
                        w_ferr  = ~w_rx_s;
                        w_perr  = c_PAR_EN & (r_p != ((^r_shift) ^ c_PAR_ODD));
                        w_done  = 1'b1;
                    end else begin
                        w_s = r_s + 5'd1;
                    end
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    assign dout         = r_dout;
    assign rx_done_tick = r_done;
    assign frame_err    = r_ferr;
    assign parity_err   = r_perr;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module  : tb_uart_rx
// Brief   : Directed self-checking bench for uart_rx (8N1 and 8E1 instances).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       s_tick = 1'b0;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;
    logic [7:0] dout_a, dout_b;
    logic       done_a, done_b;
    logic       ferr_a, ferr_b;
    logic       perr_a, perr_b;

    int n_checks = 0;
    int n_errors = 0;
    int tick_cnt = 0;

    logic [7:0] q_da[$];
    logic       q_fa[$];
    logic       q_pa[$];
    logic [7:0] q_db[$];
    logic       q_fb[$];
    logic       q_pb[$];

    uart_rx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
        .clk(clk), .rst(rst), .s_tick(s_tick), .rx(rx_a),
        .dout(dout_a), .rx_done_tick(done_a), .frame_err(ferr_a), .parity_err(perr_a)
    );

    uart_rx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
        .clk(clk), .rst(rst), .s_tick(s_tick), .rx(rx_b),
        .dout(dout_b), .rx_done_tick(done_b), .frame_err(ferr_b), .parity_err(perr_b)
    );

    always #5 clk = ~clk;

    // One-clk s_tick every fourth clock.
    always @(negedge clk) begin
        tick_cnt = (tick_cnt + 1) % 4;
        s_tick   = (tick_cnt == 0);
    end

    always @(negedge clk) begin
        if (done_a) begin
            q_da.push_back(dout_a);
            q_fa.push_back(ferr_a);
            q_pa.push_back(perr_a);
        end
        if (done_b) begin
            q_db.push_back(dout_b);
            q_fb.push_back(ferr_b);
            q_pb.push_back(perr_b);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input int line, input logic b);
        @(negedge clk);
        if (line == 0) rx_a = b;
        else           rx_b = b;
        repeat (63) @(negedge clk);
    endtask

    task automatic send_frame(input int line, input logic [7:0] data, input bit with_par,
                              input logic par_bit, input logic stop_bit);
        drive_bit(line, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(line, data[i]);
        if (with_par) drive_bit(line, par_bit);
        drive_bit(line, stop_bit);
    endtask

    task automatic idle_bits(input int line, input int nbits);
        for (int i = 0; i < nbits; i++) drive_bit(line, 1'b1);
    endtask

    task automatic expect_a(input string tag, input logic [7:0] d, input logic f);
        if (q_da.size() == 0) begin
            check({tag, "_present"}, 32'd0, 32'd1);
        end else begin
            check({tag, "_dout"}, 32'(q_da.pop_front()), 32'(d));
            check({tag, "_ferr"}, 32'(q_fa.pop_front()), 32'(f));
            check({tag, "_perr"}, 32'(q_pa.pop_front()), 32'd0);
        end
    endtask

    task automatic expect_b(input string tag, input logic [7:0] d, input logic p);
        if (q_db.size() == 0) begin
            check({tag, "_present"}, 32'd0, 32'd1);
        end else begin
            check({tag, "_dout"}, 32'(q_db.pop_front()), 32'(d));
            check({tag, "_ferr"}, 32'(q_fb.pop_front()), 32'd0);
            check({tag, "_perr"}, 32'(q_pb.pop_front()), 32'(p));
        end
    endtask

    initial begin
        logic [7:0] d99;
        d99 = 8'h99;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_dout",  32'(dout_a), 32'd0);
        check("rst_done",  32'(done_a), 32'd0);
        check("rst_ferr",  32'(ferr_a), 32'd0);
        check("rst_perr",  32'(perr_a), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        idle_bits(0, 2);

        // Single 8N1 frame
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
        idle_bits(0, 1);
        check("f55_count", 32'(q_da.size()), 32'd1);
        expect_a("f55", 8'h55, 1'b0);

        // Back-to-back frames, no idle gap
        send_frame(0, 8'hA3, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'h0F, 1'b0, 1'b0, 1'b1);
        idle_bits(0, 1);
        check("b2b_count", 32'(q_da.size()), 32'd2);
        expect_a("fA3", 8'hA3, 1'b0);
        expect_a("f0F", 8'h0F, 1'b0);

        // Short low glitch: 5 s_ticks
        @(negedge clk);
        rx_a = 1'b0;
        repeat (20) @(negedge clk);
        rx_a = 1'b1;
        idle_bits(0, 2);
        check("glitch_count", 32'(q_da.size()), 32'd0);
        check("glitch_idle", 32'(dut_a.r_state), 32'(IDLE));
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
        idle_bits(0, 1);
        expect_a("f3C", 8'h3C, 1'b0);

        // Framing error then recovery
        send_frame(0, 8'hC1, 1'b0, 1'b0, 1'b0);
        idle_bits(0, 2);
        check("fC1_count", 32'(q_da.size()), 32'd1);
        expect_a("fC1", 8'hC1, 1'b1);
        send_frame(0, 8'h12, 1'b0, 1'b0, 1'b1);
        idle_bits(0, 1);
        expect_a("f12", 8'h12, 1'b0);

        // Even parity instance
        idle_bits(1, 1);
        send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
        idle_bits(1, 1);
        expect_b("p07_good", 8'h07, 1'b0);
        send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
        idle_bits(1, 1);
        expect_b("p07_bad", 8'h07, 1'b1);
        check("p_count", 32'(q_db.size()), 32'd0);

        // Reset during data bit 4
        drive_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, d99[i]);
        @(negedge clk);
        rx_a = d99[4];
        repeat (30) @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_dout",  32'(dout_a), 32'd0);
        check("mid_rst_done",  32'(done_a), 32'd0);
        check("mid_rst_ferr",  32'(ferr_a), 32'd0);
        check("mid_rst_perr_b", 32'(perr_b), 32'd0);
        repeat (10) @(negedge clk);
        rx_a = 1'b1;
        rst  = 1'b1;
        idle_bits(0, 12);
        check("mid_rst_nodone", 32'(q_da.size()), 32'd0);
        send_frame(0, 8'h99, 1'b0, 1'b0, 1'b1);
        idle_bits(0, 1);
        check("f99_count", 32'(q_da.size()), 32'd1);
        expect_a("f99", 8'h99, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
